// File: rtl/aes_stream_ctrl.sv
// aes_stream_ctrl: FIFO-fed sequencer for iterative AES encrypt/decrypt cores.
// Define AES_STREAM_SELFCHECK_EN to add the encrypt-then-decrypt self-check.
module aes_stream_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic             out_match,
  output logic [1:0]       out_mode,
  output logic [3:0]       nr,
  output logic             enc_rst,
  output logic             enc_en,
  output logic [127:0]     enc_in,
  input  logic [127:0]     enc_out,
  output logic             dec_rst,
  output logic             dec_en,
  output logic [127:0]     dec_in,
  input  logic [127:0]     dec_out,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  output logic [CNT_W-1:0] fail_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] ENC   = 3'd2;
  localparam logic [2:0] OUT   = 3'd5;
`ifdef AES_STREAM_SELFCHECK_EN
  localparam logic [2:0] DLOAD = 3'd3;
  localparam logic [2:0] DEC   = 3'd4;
  localparam logic [2:0] ENC_NEXT = DLOAD;
`else
  localparam logic [2:0] ENC_NEXT = OUT;
`endif

  logic [2:0]    state;
  logic [3:0]    rnd;
  logic [127:0]  hold_data;
  logic [1:0]    hold_mode;
  logic [127:0]  cipher;
  logic          match;
  logic [129:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          done;

  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid && in_ready;
  assign pop      = enable && (state == IDLE) && (count != '0);
  assign done     = enable && out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_mode, in_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_comb begin
    nr = 4'd10;
    if (state != IDLE) begin
      unique case (1'b1)
        hold_mode[1]:         nr = 4'd14;
        (hold_mode == 2'b01): nr = 4'd12;
        (hold_mode == 2'b00): nr = 4'd10;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rnd        <= '0;
      hold_data  <= '0;
      hold_mode  <= '0;
      cipher     <= '0;
      match      <= 1'b0;
      blk_count  <= '0;
      fail_count <= '0;
    end else if (enable) begin
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            {hold_mode, hold_data} <= mem[rd_ptr];
            state <= LOAD;
          end
        end
        LOAD: begin
          rnd   <= '0;
          state <= ENC;
        end
        ENC: begin
          if (rnd == nr) begin
            cipher <= enc_out;
            rnd    <= '0;
            state  <= ENC_NEXT;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
`ifdef AES_STREAM_SELFCHECK_EN
        DLOAD: begin
          rnd   <= '0;
          state <= DEC;
        end
        DEC: begin
          if (rnd == nr) begin
            match <= (dec_out == hold_data);
            state <= OUT;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
`endif
        OUT: begin
          if (out_ready) begin
            state <= IDLE;
            if (blk_count != '1)
              blk_count <= blk_count + CNT_W'(1);
            if (!out_match && fail_count != '1)
              fail_count <= fail_count + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == OUT);
  assign out_data  = cipher;
  assign out_mode  = hold_mode;
  assign busy      = (state != IDLE);
  assign enc_rst   = (state == IDLE) || (state == LOAD);
  assign enc_en    = enable && (state == ENC);
  assign enc_in    = hold_data;
  assign dec_in    = cipher;

`ifdef AES_STREAM_SELFCHECK_EN
  assign dec_rst   = (state != DEC);
  assign dec_en    = enable && (state == DEC);
  assign out_match = match;
`else
  // Without the decrypt pass every block is reported as matching.
  logic unused_dec;
  assign unused_dec = ^{dec_out, match, done};
  assign dec_rst    = 1'b1;
  assign dec_en     = 1'b0;
  assign out_match  = 1'b1;
`endif

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// tb_aes_stream_ctrl: scoreboard bench for aes_stream_ctrl with
// table-driven encrypt/decrypt core models.
module tb_aes_stream_ctrl;

`ifdef AES_STREAM_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif
  localparam int D = 4;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk = 1'b0;
  logic         reset_n, enable, in_valid, in_ready;
  logic [127:0] in_data;
  logic [1:0]   in_mode;
  logic         out_valid, out_ready, out_match;
  logic [127:0] out_data;
  logic [1:0]   out_mode;
  logic [3:0]   nr;
  logic         enc_rst, enc_en, dec_rst, dec_en, busy;
  logic [127:0] enc_in, enc_out, dec_in, dec_out;
  logic [15:0]  blk_count, fail_count;

  aes_stream_ctrl #(.FIFO_DEPTH(D), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_match(out_match),
    .out_mode(out_mode), .nr(nr),
    .enc_rst(enc_rst), .enc_en(enc_en),
    .enc_in(enc_in), .enc_out(enc_out),
    .dec_rst(dec_rst), .dec_en(dec_en),
    .dec_in(dec_in), .dec_out(dec_out),
    .busy(busy), .blk_count(blk_count),
    .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core models: known FIPS-197 vectors, otherwise an invertible stand-in.
  function automatic logic [127:0] aes_enc(input logic [127:0] p,
                                           input logic [3:0] n);
    if (p == PT && n == 4'd10) return C128;
    if (p == PT && n == 4'd12) return C192;
    if (p == PT && n == 4'd14) return C256;
    return ~p ^ {124'd0, n};
  endfunction

  function automatic logic [127:0] aes_dec(input logic [127:0] c,
                                           input logic [3:0] n);
    if (c == C128 && n == 4'd10) return PT;
    if (c == C192 && n == 4'd12) return PT;
    if (c == C256 && n == 4'd14) return PT;
    return ~(c ^ {124'd0, n});
  endfunction

  logic [127:0] e_src, d_src;
  int           e_cnt, d_cnt;
  logic         corrupt;

  always @(posedge clk) begin
    if (enc_rst) begin
      e_src <= enc_in;
      e_cnt <= 0;
    end else if (enc_en) begin
      e_cnt <= e_cnt + 1;
    end
    if (dec_rst) begin
      d_src <= dec_in;
      d_cnt <= 0;
    end else if (dec_en) begin
      d_cnt <= d_cnt + 1;
    end
  end

  assign enc_out = (e_cnt == int'(nr)) ? aes_enc(e_src, nr)
                 : e_src ^ {4{32'hdeadbeef}} ^ 128'(e_cnt);
  assign dec_out = (d_cnt == int'(nr))
                 ? aes_dec(d_src, nr) ^ {127'd0, corrupt}
                 : d_src ^ {4{32'h5a5a1234}} ^ 128'(d_cnt);

  typedef struct {
    logic [127:0] data;
    logic [1:0]   mode;
    logic         match;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && out_valid && out_ready && enable) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_mode", {126'd0, out_mode}, {126'd0, e.mode});
        chk("out_match", {127'd0, out_match}, {127'd0, e.match});
      end
    end
  end

  task automatic push_blk(input logic [127:0] d, input logic [1:0] m,
                          input logic [127:0] c, input logic mt,
                          output int t);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stayed 0 expected 1");
    end
    sb.push_back('{c, m, mt});
    @(posedge clk); #1;
    t = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int t);
    int n = 0;
    while (!out_valid && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: out_valid 0 expected 1");
    end
    t = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_done", {127'd0, (sb.size() != 0) || busy}, 128'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int t0, t1, t, acc, stalled_at, stall_cyc, guard, seen;
    reset_n = 1'b0; enable = 1'b1; in_valid = 1'b0;
    in_data = '0; in_mode = '0; out_ready = 1'b1; corrupt = 1'b0;
    #3;
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_match", {127'd0, out_match}, {127'd0, !SC});
    chk("rst_out_mode", {126'd0, out_mode}, 128'd0);
    chk("rst_enc_rst", {127'd0, enc_rst}, 128'd1);
    chk("rst_dec_rst", {127'd0, dec_rst}, 128'd1);
    chk("rst_enc_en", {127'd0, enc_en}, 128'd0);
    chk("rst_dec_en", {127'd0, dec_en}, 128'd0);
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_nr", {124'd0, nr}, 128'd10);
    chk("rst_blk", {112'd0, blk_count}, 128'd0);
    chk("rst_fail", {112'd0, fail_count}, 128'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    push_blk(PT, 2'b00, C128, 1'b1, t0);
    wait_valid(t);
    chk("lat_aes128", 128'(t - t0), SC ? 128'd25 : 128'd13);
    drain();

    push_blk(PT, 2'b01, C192, 1'b1, t0);
    push_blk(PT, 2'b10, C256, 1'b1, t1);
    chk("nr_aes192", {124'd0, nr}, 128'd12);
    drain();

    out_ready  = 1'b0;
    acc        = 0;
    stalled_at = -1;
    stall_cyc  = 0;
    guard      = 0;
    in_valid   = 1'b1;
    in_mode    = 2'b00;
    while (acc < D + 2 && guard < 600) begin
      in_data = 128'h0f0f_0000 + 128'(acc);
      if (in_ready) begin
        sb.push_back('{~in_data ^ 128'd10, 2'b00, 1'b1});
        @(posedge clk); #1;
        acc++;
      end else begin
        if (stalled_at < 0) stalled_at = acc;
        stall_cyc++;
        if (stall_cyc == 40) out_ready = 1'b1;
        @(posedge clk); #1;
      end
      guard++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("fifo_full_accepts", 128'(stalled_at), 128'(D + 1));
    chk("fifo_total_accepts", 128'(acc), 128'(D + 2));
    drain();
    chk("blk_count_9", {112'd0, blk_count}, 128'd9);
    chk("fail_count_0", {112'd0, fail_count}, 128'd0);

    do_reset();
    corrupt = 1'b1;
    push_blk(PT, 2'b00, C128, !SC, t0);
    drain();
    corrupt = 1'b0;
    chk("mm_blk", {112'd0, blk_count}, 128'd1);
    chk("mm_fail", {112'd0, fail_count}, SC ? 128'd1 : 128'd0);

    push_blk(PT, 2'b11, C256, 1'b1, t0);
    repeat (4) begin @(posedge clk); #1; end
    chk("stall_enc_en_before", {127'd0, enc_en}, 128'd1);
    enable = 1'b0;
    #1;
    chk("stall_enc_en_low", {127'd0, enc_en}, 128'd0);
    chk("stall_nr", {124'd0, nr}, 128'd14);
    repeat (5) begin @(posedge clk); #1; end
    enable = 1'b1;
    wait_valid(t);
    chk("lat_stall", 128'(t - t0), SC ? 128'd38 : 128'd22);
    drain();

    push_blk(PT, 2'b00, C128, 1'b1, t0);
    push_blk(128'h1, 2'b00, ~128'h1 ^ 128'd10, 1'b1, t1);
    push_blk(128'h2, 2'b00, ~128'h2 ^ 128'd10, 1'b1, t1);
    guard = 0;
    while (cyc - t0 < (SC ? 18 : 6) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("pre_reset_core_en", {127'd0, SC ? dec_en : enc_en}, 128'd1);
    reset_n = 1'b0;
    #1;
    sb.delete();
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_out_valid", {127'd0, out_valid}, 128'd0);
    chk("abort_in_ready", {127'd0, in_ready}, 128'd1);
    chk("abort_blk", {112'd0, blk_count}, 128'd0);
    chk("abort_fail", {112'd0, fail_count}, 128'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1;
    end
    chk("abort_discard", 128'(seen), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
